mc_controller: RTL and testbench

Multi-cycle successor to the single-cycle MIPS controller. A state machine steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and asserts datapath controls only in the cycle they apply. Instruction and data memory are reached through a req/ack handshake with a parametrised timeout. It sits between the IR and the multi-cycle datapath (PC, GRF, ALU, EXT, DM).

---
 rtl/mc_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//
// Multi-cycle MIPS-subset controller. A state machine walks each instruction
// through FETCH, DECODE, EXEC, MEM and WB. Each datapath control is asserted
// only in the cycle where it takes effect. Instruction and data memory use a
// req/ack handshake. If a request stays unacknowledged for TIMEOUT cycles,
// the controller enters a terminal ERR state, which only reset clears.
//
// Supported: addu, subu, ori, lui, lw, sw, beq, jal, jr. Any other encoding,
// including nop, just advances the PC from DECODE.
//
// Optional build macro: CTRL_PERF_EN
//   defined   - cycle_cnt counts non-IDLE cycles, instr_cnt counts PCWE cycles
//   undefined - both counters read constant 0 and no counter flops are built
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   instr      in   IR contents, valid from DECODE onward
//   imem_req   out  instruction fetch request       imem_ack  in  fetch done
//   dmem_req   out  data access request (lw/sw)     dmem_ack  in  access done
//   IRWE       out  IR load enable                  PCWE      out PC update
//   MUX1       out  GRF waddr: 00 rt, 01 rd, 10 $31
//   MUX2       out  ALU B: 0 rt, 1 EXT
//   MUX3       out  GRF wdata: 00 ALU, 01 DM, 10 PC+4
//   GRFWE      out  register file write
//   DMWE/DMRE  out  DM write / read qualifiers for dmem_req
//   NPCOp      out  00 PC+4, 01 beq, 10 jal, 11 jr
//   ALUOp      out  00 add, 01 sub, 10 or, 11 equal-compare
//   EXTOp      out  00 sign, 01 zero, 10 lui shift
//   err        out  sticky memory-timeout flag
//   cycle_cnt  out  cycles since reset (perf build)
//   instr_cnt  out  instructions retired (perf build)
// ---------------------------------------------------------------------------
module mc_controller #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              dmem_req,
    input  logic              dmem_ack,
    output logic              IRWE,
    output logic              PCWE,
    output logic [1:0]        MUX1,
    output logic              MUX2,
    output logic [1:0]        MUX3,
    output logic              GRFWE,
    output logic              DMWE,
    output logic              DMRE,
    output logic [1:0]        NPCOp,
    output logic [1:0]        ALUOp,
    output logic [1:0]        EXTOp,
    output logic              err,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Last count value a request may reach before the wait is declared dead.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [5:0] opcode, funct;
    logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_jr;
    logic is_alu_r, is_alu_i, is_known;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign is_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
    assign is_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
    assign is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_jal   = (opcode == OP_JAL);
    assign is_alu_r = is_addu | is_subu;
    assign is_alu_i = is_ori | is_lui;
    assign is_known = is_alu_r | is_alu_i | is_lw | is_sw | is_beq | is_jal | is_jr;

    // Register/immediate fields are consumed by the datapath, not by control.
    logic unused_instr_fields;
    assign unused_instr_fields = ^instr[25:6];

    // ------------------------------------------------------------------
    // Next state, timeout and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so
        // no path can leave one unassigned and infer a latch.
        state_d  = state_q;
        to_d     = '0;        // cleared on every ack and every state change
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IRWE     = 1'b0;
        PCWE     = 1'b0;
        MUX1     = 2'b00;
        MUX2     = 1'b0;
        MUX3     = 2'b00;
        GRFWE    = 1'b0;
        DMWE     = 1'b0;
        DMRE     = 1'b0;
        NPCOp    = 2'b00;
        ALUOp    = 2'b00;
        EXTOp    = 2'b00;
        err      = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                imem_req = 1'b1;
                // An ack in the last allowed cycle beats the timeout.
                if (imem_ack) begin
                    IRWE    = 1'b1;
                    state_d = DECODE;
                end else if (to_q == TO_LAST) begin
                    state_d = ERR;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            DECODE: begin
                if (is_jal) begin
                    state_d = WB;
                end else if (is_known) begin
                    state_d = EXEC;
                end else begin
                    // nop and unsupported encodings simply step the PC.
                    PCWE    = 1'b1;
                    state_d = FETCH;
                end
            end

            EXEC: begin
                MUX2 = is_alu_i | is_lw | is_sw;
                if (is_subu)       ALUOp = 2'b01;
                else if (is_alu_i) ALUOp = 2'b10;
                else if (is_beq)   ALUOp = 2'b11;
                if (is_ori)        EXTOp = 2'b01;
                else if (is_lui)   EXTOp = 2'b10;

                if (is_beq) begin
                    // The datapath chooses taken/not-taken from the compare.
                    PCWE    = 1'b1;
                    NPCOp   = 2'b01;
                    state_d = FETCH;
                end else if (is_jr) begin
                    PCWE    = 1'b1;
                    NPCOp   = 2'b11;
                    state_d = FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end

            MEM: begin
                dmem_req = 1'b1;
                DMRE     = is_lw;
                DMWE     = is_sw;
                if (dmem_ack) begin
                    // A store retires in its ack cycle; a load still writes back.
                    PCWE    = is_sw;
                    state_d = is_sw ? FETCH : WB;
                end else if (to_q == TO_LAST) begin
                    state_d = ERR;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            WB: begin
                GRFWE   = 1'b1;
                PCWE    = 1'b1;
                state_d = FETCH;
                if (is_jal) begin
                    MUX1  = 2'b10;
                    MUX3  = 2'b10;
                    NPCOp = 2'b10;
                end else if (is_alu_r) begin
                    MUX1 = 2'b01;
                end else if (is_lw) begin
                    MUX3 = 2'b01;
                end
            end

            ERR: err = 1'b1;   // terminal until reset

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            to_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that
            // every flop samples the pre-edge values of the others.
            state_q <= state_d;
            to_q    <= to_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] cycle_q, cycle_d;
    logic [PERF_W-1:0] retired_q, retired_d;

    always_comb begin
        cycle_d   = cycle_q;
        retired_d = retired_q;
        if (state_q != IDLE) cycle_d   = cycle_q + PERF_W'(1);
        if (PCWE)            retired_d = retired_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = retired_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
//
// Self-checking bench for mc_controller. The reference model works one
// instruction at a time. It expands each instruction class into its list of
// phases (fetch wait, decode, exec, memory wait, write-back). It then
// predicts the exact control word for every cycle under randomized ack
// latencies, spurious acks and operand bits. Outputs are sampled 1 ns
// after the falling edge.
// ---------------------------------------------------------------------------
module tb_mc_controller;

    localparam int TO     = 16;
    localparam int PERF_W = 32;

    typedef enum int {
        C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR, C_OTHER
    } cls_t;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       irwe;
        logic       pcwe;
        logic [1:0] mux1;
        logic       mux2;
        logic [1:0] mux3;
        logic       grfwe;
        logic       dmwe;
        logic       dmre;
        logic [1:0] npc;
        logic [1:0] alu;
        logic [1:0] ext;
        logic       err;
    } ctl_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       instr;
    logic              imem_req, imem_ack, dmem_req, dmem_ack;
    logic              irwe, pcwe, mux2, grfwe, dmwe, dmre, err;
    logic [1:0]        mux1, mux3, npc_op, alu_op, ext_op;
    logic [PERF_W-1:0] cycle_cnt, instr_cnt;
    ctl_t              dut_ctl;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_m = 0;   // model: non-IDLE cycles since reset
    int ins_m = 0;   // model: PCWE cycles since reset

    always #5 clk = ~clk;

    mc_controller #(.TIMEOUT(TO), .TO_W(5), .PERF_W(PERF_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .imem_req (imem_req),
        .imem_ack (imem_ack),
        .dmem_req (dmem_req),
        .dmem_ack (dmem_ack),
        .IRWE     (irwe),
        .PCWE     (pcwe),
        .MUX1     (mux1),
        .MUX2     (mux2),
        .MUX3     (mux3),
        .GRFWE    (grfwe),
        .DMWE     (dmwe),
        .DMRE     (dmre),
        .NPCOp    (npc_op),
        .ALUOp    (alu_op),
        .EXTOp    (ext_op),
        .err      (err),
        .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt)
    );

    assign dut_ctl = {imem_req, dmem_req, irwe, pcwe, mux1, mux2, mux3,
                      grfwe, dmwe, dmre, npc_op, alu_op, ext_op, err};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, want);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cls_t classify(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        case (op)
            6'h00: begin
                if (fn == 6'h21)      return C_ADDU;
                else if (fn == 6'h23) return C_SUBU;
                else if (fn == 6'h08) return C_JR;
                else                  return C_OTHER;
            end
            6'h0d:   return C_ORI;
            6'h0f:   return C_LUI;
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h04:   return C_BEQ;
            6'h03:   return C_JAL;
            default: return C_OTHER;
        endcase
    endfunction

    // A random instruction word of the requested class with random operands.
    function automatic logic [31:0] gen(input cls_t c);
        logic [31:0] w;
        w = $urandom;
        case (c)
            C_ADDU:  begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
            C_SUBU:  begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
            C_JR:    begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
            C_ORI:   w[31:26] = 6'h0d;
            C_LUI:   w[31:26] = 6'h0f;
            C_LW:    w[31:26] = 6'h23;
            C_SW:    w[31:26] = 6'h2b;
            C_BEQ:   w[31:26] = 6'h04;
            C_JAL:   w[31:26] = 6'h03;
            default: begin
                if (rb()) w = 32'h0;   // nop
                else while (classify(w) != C_OTHER) w = $urandom;
            end
        endcase
        return w;
    endfunction

    // Drive one cycle's inputs (caller is at a falling edge), check the control
    // word, update the perf model, and advance to the next falling edge.
    task automatic step(input string tag, input ctl_t want, input logic ia,
                        input logic da, input logic [31:0] iw, input bit active);
        imem_ack = ia;
        dmem_ack = da;
        instr    = iw;
        #1;
        check(tag, 64'(dut_ctl), 64'(want));
        if (active)    cyc_m++;
        if (want.pcwe) ins_m++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_perf(input string tag);
`ifdef CTRL_PERF_EN
        check({tag, "_cycles"}, 64'(cycle_cnt), 64'(cyc_m));
        check({tag, "_instrs"}, 64'(instr_cnt), 64'(ins_m));
`else
        check({tag, "_cycles"}, 64'(cycle_cnt), 64'd0);
        check({tag, "_instrs"}, 64'(instr_cnt), 64'd0);
`endif
    endtask

    // Caller is at a falling edge. Reset is held for one full cycle, then
    // released; the following IDLE cycle must show every output at 0.
    task automatic do_reset();
        reset = 1'b0;
        cyc_m = 0;
        ins_m = 0;
        #1;
        check("rst_outputs", 64'(dut_ctl), 64'd0);
        check_perf("rst_perf");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step("idle", '0, rb(), rb(), $urandom, 1'b0);
    endtask

    task automatic enter_err();
        ctl_t e;
        for (int k = 0; k < 6; k++) begin
            e     = '0;
            e.err = 1'b1;
            step("err_sticky", e, rb(), rb(), $urandom, 1'b1);
        end
        check_perf("err_perf");
    endtask

    // One instruction. fd/md = cycles without ack before the ack arrives in
    // FETCH/MEM (>= TO means the ack never comes). abort_at >= 0 pulses reset
    // in that MEM wait cycle and returns with reset held low.
    task automatic run_instr(input logic [31:0] iw, input int fd, input int md,
                             input int abort_at);
        ctl_t        e;
        cls_t        c;
        logic        ack;
        logic [31:0] junk;
        int          n;

        check_perf("perf");
        c    = classify(iw);
        junk = $urandom;

        // FETCH: the IR still holds stale contents.
        n = (fd < TO) ? fd + 1 : TO;
        for (int i = 0; i < n; i++) begin
            ack        = (i == fd);
            e          = '0;
            e.imem_req = 1'b1;
            e.irwe     = ack;
            step("fetch", e, ack, rb(), junk, 1'b1);
        end
        if (fd >= TO) begin
            enter_err();
            return;
        end

        // DECODE
        e = '0;
        if (c == C_OTHER) begin
            e.pcwe = 1'b1;
            step("decode_skip", e, rb(), rb(), iw, 1'b1);
            return;
        end
        step("decode", e, rb(), rb(), iw, 1'b1);

        // EXEC
        if (c != C_JAL) begin
            e = '0;
            case (c)
                C_SUBU: e.alu = 2'b01;
                C_ORI:  begin e.mux2 = 1'b1; e.alu = 2'b10; e.ext = 2'b01; end
                C_LUI:  begin e.mux2 = 1'b1; e.alu = 2'b10; e.ext = 2'b10; end
                C_LW,
                C_SW:   e.mux2 = 1'b1;
                C_BEQ:  begin e.alu = 2'b11; e.pcwe = 1'b1; e.npc = 2'b01; end
                C_JR:   begin e.pcwe = 1'b1; e.npc = 2'b11; end
                default: ;
            endcase
            step("exec", e, rb(), rb(), iw, 1'b1);
            if (c == C_BEQ || c == C_JR) return;
        end

        // MEM
        if (c == C_LW || c == C_SW) begin
            n = (md < TO) ? md + 1 : TO;
            for (int i = 0; i < n; i++) begin
                if (i == abort_at) begin
                    imem_ack = 1'b0;
                    dmem_ack = 1'b0;
                    instr    = iw;
                    #1;
                    check("mem_wait_req", 64'(dmem_req), 64'd1);
                    #2;
                    reset = 1'b0;
                    #1;
                    check("rst_async_drop", 64'(dut_ctl), 64'd0);
                    return;
                end
                ack        = (i == md);
                e          = '0;
                e.dmem_req = 1'b1;
                e.dmre     = (c == C_LW);
                e.dmwe     = (c == C_SW);
                e.pcwe     = ack && (c == C_SW);
                step("mem", e, rb(), ack, iw, 1'b1);
            end
            if (md >= TO) begin
                enter_err();
                return;
            end
            if (c == C_SW) return;
        end

        // WB
        e       = '0;
        e.grfwe = 1'b1;
        e.pcwe  = 1'b1;
        case (c)
            C_ADDU, C_SUBU: e.mux1 = 2'b01;
            C_LW:           e.mux3 = 2'b01;
            C_JAL:          begin e.mux1 = 2'b10; e.mux3 = 2'b10; e.npc = 2'b10; end
            default: ;
        endcase
        step("wb", e, rb(), rb(), iw, 1'b1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cls_t c;
        int   fd, md;

        reset    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        instr    = 32'h0;
        @(negedge clk);
        do_reset();

        // addu / sw / nop with immediate acks: 10 active cycles, 3 retired.
        run_instr(gen(C_ADDU), 0, 0, -1);
        run_instr(gen(C_SW), 0, 0, -1);
        run_instr(32'h0, 0, 0, -1);
`ifdef CTRL_PERF_EN
        check("perf10_instrs", 64'(instr_cnt), 64'd3);
        check("perf10_cycles", 64'(cycle_cnt), 64'd10);
`else
        check("perf10_instrs", 64'(instr_cnt), 64'd0);
        check("perf10_cycles", 64'(cycle_cnt), 64'd0);
`endif

        // Directed coverage of every class and the ack boundaries.
        run_instr(gen(C_LW), 0, 3, -1);
        run_instr(gen(C_BEQ), 0, 0, -1);
        run_instr(gen(C_JAL), 0, 0, -1);
        run_instr(gen(C_JR), 0, 0, -1);
        run_instr(gen(C_ORI), 1, 0, -1);
        run_instr(gen(C_LUI), 0, 0, -1);
        run_instr(gen(C_SUBU), 2, 0, -1);
        run_instr(gen(C_OTHER), 0, 0, -1);
        run_instr(gen(C_ADDU), TO - 1, 0, -1);   // ack in the 16th fetch cycle
        run_instr(gen(C_LW), 0, TO - 1, -1);     // ack in the 16th mem cycle
        run_instr(gen(C_SW), TO - 1, TO - 1, -1);

        // Reset mid store-wait, then normal restart.
        run_instr(gen(C_SW), 0, 8, 3);
        @(negedge clk);
        do_reset();
        run_instr(gen(C_ADDU), 0, 0, -1);

        // Fetch timeout, then data timeout.
        run_instr(gen(C_ADDU), TO, 0, -1);
        do_reset();
        run_instr(gen(C_LW), 0, TO, -1);
        do_reset();

        // Randomized instruction stream.
        for (int k = 0; k < 200; k++) begin
            c  = cls_t'($urandom_range(0, 9));
            fd = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            md = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            run_instr(gen(c), fd, md, -1);
        end
        check_perf("final_perf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
